// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signal bundle for alu_cmd_sequencer.
// slave = the sequencer; master = the command source, ALU and response consumer.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic             cmd_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;
    logic             alu_n;
    logic             alu_z;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_flags;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc,
        input  alu_y, alu_c, alu_v, alu_n, alu_z,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_y, rsp_flags, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc,
        output alu_y, alu_c, alu_v, alu_n, alu_z,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_y, rsp_flags, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for a combinational ALU: accept, one settle
// cycle, then hold the captured result and flags until the consumer takes them.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic [WIDTH-1:0] acc_reg;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_valid && bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready/busy are registered copies of the next state, so they track the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            bus.cmd_ready <= (state_nxt == IDLE);
            bus.busy      <= (state_nxt != IDLE);
        end
    end

    // operand registers, loaded only on an accepted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
        end else if (accept) begin
            bus.alu_a  <= WIDTH'(bus.cmd_acc ? acc_reg : bus.cmd_a);
            bus.alu_b  <= WIDTH'(bus.cmd_b);
            bus.alu_op <= OPW'(bus.cmd_op);
        end
    end

    // result capture at the end of the settle cycle; acc_reg ignores backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_flags <= '0;
            acc_reg       <= '0;
        end else if (state == EXEC) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_y     <= WIDTH'(bus.alu_y);
            bus.rsp_flags <= {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_z};
            acc_reg       <= WIDTH'(bus.alu_y);
        end else if (state == RESP && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives the
// result bus, and expected responses come from an in-order command-level model.
module tb_alu_cmd_sequencer;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_cmd_sequencer #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m_acc;
    logic [19:0] exp_q[$];

    // Behavioural ALU: returns {Y, C, V, N, Z}; C/V/N masked for logical ops
    function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        logic [16:0] s;
        logic [15:0] y;
        logic        c, v, n;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd3: y = a ^ b;
            3'd2: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (y[15] != a[15]);
            end
            3'd6: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[15:0];
                c = s[16];
                v = (a[15] != b[15]) && (y[15] != a[15]);
            end
            default: begin
                y = {a[7:0], b[15:8]} ^ 16'h5A5A;
                c = 1'b1;
                v = op[0];
            end
        endcase
        n = (op == 3'd0 || op == 3'd1 || op == 3'd3) ? 1'b0 : y[15];
        return {y, c, v, n, (y == 16'h0000)};
    endfunction

    assign {bus.alu_y, bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_z} =
        alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    // Command-level model: operand A comes from the last result when chaining
    function automatic logic [19:0] model_cmd(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op, input logic acc);
        logic [19:0] r;
        r = alu_model(acc ? m_acc : a, b, op);
        m_acc = r[19:4];
        return r;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic acc, output bit ok);
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_acc = acc;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic xact(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic acc, output logic [15:0] y, output logic [3:0] f,
                        output bit ok);
        bus.rsp_ready = 1'b1;
        y = 'x; f = 'x;
        issue(a, b, op, acc, ok);
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (bus.rsp_valid === 1'b1) begin
                    ok = 1'b1; y = bus.rsp_y; f = bus.rsp_flags;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit quiet;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.cmd_acc = 1'b0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_flags, bus.alu_op} !== 10'b0100000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got v/rdy/busy/flags/op=%b expected 0100000000",
                     {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_flags, bus.alu_op});
        end
        n_cmp++;
        if ({bus.rsp_y, bus.alu_a, bus.alu_b} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: got y/a/b=%h expected 0", {bus.rsp_y, bus.alu_a, bus.alu_b});
        end
        rst = 1'b0;
        m_acc = '0;
        bus.rsp_ready = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_err++;
            $display("FAIL idle_early_ready: got spurious activity expected rsp_valid=0 cmd_ready=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_latency();
        bit ok;
        logic [19:0] e;
        bus.rsp_ready = 1'b1;
        e = model_cmd(16'h0003, 16'h0004, 3'b010, 1'b0);
        issue(16'h0003, 16'h0004, 3'b010, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL add_accept: got timeout expected accept"); end
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b001) begin
            n_err++;
            $display("FAIL add_exec_ctrl: got v/rdy/busy=%b expected 001",
                     {bus.rsp_valid, bus.cmd_ready, bus.busy});
        end
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {16'h0003, 16'h0004, 3'b010}) begin
            n_err++;
            $display("FAIL add_operands: got a=%h b=%h op=%b expected 0003 0004 010",
                     bus.alu_a, bus.alu_b, bus.alu_op);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_y, bus.rsp_flags} !== {2'b10, 16'h0007, 4'b0000}) begin
            n_err++;
            $display("FAIL add_resp: got v=%b rdy=%b y=%h f=%b expected 1 0 0007 0000",
                     bus.rsp_valid, bus.cmd_ready, bus.rsp_y, bus.rsp_flags);
        end
        n_cmp++;
        if ({bus.rsp_y, bus.rsp_flags} !== e) begin
            n_err++;
            $display("FAIL add_model: got %h expected %h", {bus.rsp_y, bus.rsp_flags}, e);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
            n_err++;
            $display("FAIL add_return_idle: got v/rdy/busy=%b expected 010",
                     {bus.rsp_valid, bus.cmd_ready, bus.busy});
        end
    endtask

    task automatic test_flags();
        bit ok;
        logic [15:0] y;
        logic [3:0]  f;
        void'(model_cmd(16'h7FFF, 16'h0001, 3'b010, 1'b0));
        xact(16'h7FFF, 16'h0001, 3'b010, 1'b0, y, f, ok);
        n_cmp++;
        if (!ok || y !== 16'h8000 || f !== 4'b0110) begin
            n_err++;
            $display("FAIL overflow_add: got ok=%b y=%h f=%b expected 1 8000 0110", ok, y, f);
        end
        void'(model_cmd(16'hF0F0, 16'h0F0F, 3'b000, 1'b0));
        xact(16'hF0F0, 16'h0F0F, 3'b000, 1'b0, y, f, ok);
        n_cmp++;
        if (!ok || y !== 16'h0000 || f !== 4'b0001) begin
            n_err++;
            $display("FAIL zero_and: got ok=%b y=%h f=%b expected 1 0000 0001", ok, y, f);
        end
    endtask

    task automatic test_chain();
        bit ok;
        logic [15:0] y;
        logic [3:0]  f;
        logic [15:0] junk;
        void'(model_cmd(16'h0010, 16'h0020, 3'b010, 1'b0));
        xact(16'h0010, 16'h0020, 3'b010, 1'b0, y, f, ok);
        n_cmp++;
        if (!ok || y !== 16'h0030) begin
            n_err++;
            $display("FAIL chain_first: got ok=%b y=%h expected 1 0030", ok, y);
        end
        junk = 16'($urandom);
        void'(model_cmd(junk, 16'h0005, 3'b010, 1'b1));
        xact(junk, 16'h0005, 3'b010, 1'b1, y, f, ok);
        n_cmp++;
        if (!ok || y !== 16'h0035) begin
            n_err++;
            $display("FAIL chain_acc: got ok=%b y=%h expected 1 0035", ok, y);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        logic [15:0] a, b;
        logic [19:0] e, e2;
        a = 16'($urandom); b = 16'($urandom);
        bus.rsp_ready = 1'b0;
        e = model_cmd(a, b, 3'b010, 1'b0);
        issue(a, b, 3'b010, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_accept: got timeout expected accept"); end
        // a second command is held on the bus for the whole stall
        bus.cmd_a = ~a; bus.cmd_b = ~b; bus.cmd_op = 3'b001; bus.cmd_acc = 1'b0;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_y, bus.rsp_flags,
                 bus.alu_a, bus.alu_b, bus.alu_op} !== {2'b10, e, a, b, 3'b010}) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_err++;
            $display("FAIL bp_stall: got y=%h f=%b a=%h rdy=%b expected y/f=%h a=%h rdy=0",
                     bus.rsp_y, bus.rsp_flags, bus.alu_a, bus.cmd_ready, e, a);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got v/rdy=%b expected 01", {bus.rsp_valid, bus.cmd_ready});
        end
        @(posedge clk); #1;
        e2 = model_cmd(~a, ~b, 3'b001, 1'b0);
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if ({bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b0, ~a, ~b, 3'b001}) begin
            n_err++;
            $display("FAIL bp_held_accept: got rdy=%b a=%h b=%h op=%b expected 0 %h %h 001",
                     bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_op, ~a, ~b);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_y, bus.rsp_flags} !== {1'b1, e2}) begin
            n_err++;
            $display("FAIL bp_held_resp: got v=%b y/f=%h expected 1 %h",
                     bus.rsp_valid, {bus.rsp_y, bus.rsp_flags}, e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bit ok;
        bit quiet;
        logic [15:0] y;
        logic [3:0]  f;
        bus.rsp_ready = 1'b0;
        issue(16'($urandom), 16'($urandom), 3'b010, 1'b0, ok);
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || bus.rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_resp: got ok=%b v=%b expected 1 1", ok, bus.rsp_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_y, bus.rsp_flags,
             bus.alu_a, bus.alu_b, bus.alu_op} !== {3'b010, 55'h0}) begin
            n_err++;
            $display("FAIL rst_mid_resp: got v=%b rdy=%b busy=%b y=%h f=%b a=%h expected 0 1 0 0 0 0",
                     bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_y, bus.rsp_flags, bus.alu_a);
        end
        @(negedge clk) rst = 1'b0;
        m_acc = '0;
        bus.rsp_ready = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL rst_no_spurious: got rsp_valid after reset expected none"); end
        @(posedge clk); #1;
        issue(16'($urandom), 16'($urandom), 3'b110, 1'b0, ok);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || {bus.busy, bus.cmd_ready, bus.alu_a} !== {2'b01, 16'h0}) begin
            n_err++;
            $display("FAIL rst_mid_exec: got ok=%b busy=%b rdy=%b a=%h expected 1 0 1 0000",
                     ok, bus.busy, bus.cmd_ready, bus.alu_a);
        end
        @(negedge clk) rst = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL rst_exec_no_resp: got rsp_valid=1 expected 0"); end
        @(posedge clk); #1;
        void'(model_cmd(16'hBEEF, 16'h0009, 3'b010, 1'b1));
        xact(16'hBEEF, 16'h0009, 3'b010, 1'b1, y, f, ok);
        n_cmp++;
        if (!ok || y !== 16'h0009) begin
            n_err++;
            $display("FAIL chain_after_reset: got ok=%b y=%h expected 1 0009", ok, y);
        end
    endtask

    task automatic test_back_to_back();
        int  got;
        bit  drv_ok;
        bit  quiet;
        got = 0;
        drv_ok = 1'b1;
        bus.rsp_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [15:0] a, b;
                    logic [2:0]  op;
                    logic        acc;
                    bit          ok;
                    a = 16'($urandom); b = 16'($urandom);
                    op = 3'($urandom_range(0, 7)); acc = 1'($urandom_range(0, 1));
                    exp_q.push_back(model_cmd(a, b, op, acc));
                    issue(a, b, op, acc, ok);
                    if (!ok) drv_ok = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 1500 && got < 8; c++) begin
                    @(negedge clk);
                    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                        logic [19:0] e;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
                        n_cmp++;
                        if ({bus.rsp_y, bus.rsp_flags} !== e) begin
                            n_err++;
                            $display("FAIL stream_rsp%0d: got y/f=%h expected %h",
                                     got, {bus.rsp_y, bus.rsp_flags}, e);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        n_cmp++;
        if (!drv_ok || got != 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stream_count: got drv_ok=%b responses=%0d pending=%0d expected 1 8 0",
                     drv_ok, got, exp_q.size());
        end
        bus.rsp_ready = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL stream_duplicate: got extra rsp_valid expected none"); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_latency();
        test_flags();
        test_chain();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Registered command front-end that drives the 16-bit combinational ALU (operands A, B, 3-bit Op) and captures its result Y and flags C, V, N, Z.
- Accepts one command per valid/ready handshake and holds the operands stable for one settle cycle.
- Returns the captured result plus flags through a valid/ready response port with backpressure.
- Supports accumulator chaining: a command may take the previous captured result as operand A.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- OPW, 3, opcode width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  WIDTH  operand A; ignored when cmd_acc=1.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  OPW  ALU opcode, passed through unmodified.
- cmd_acc  in  1  1 = use acc_reg as operand A.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  OPW  to ALU Op.
- alu_y  in  WIDTH  ALU result Y.
- alu_c, alu_v, alu_n, alu_z  in  1 each  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  WIDTH  captured result.
- rsp_flags  out  4  {C,V,N,Z} captured.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; alu_a, alu_b, alu_op, rsp_y, rsp_flags, acc_reg = 0; rsp_valid=0; cmd_ready=1; busy=0.
- FSM has three states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register the operands: alu_a = cmd_acc ? acc_reg : cmd_a; alu_b = cmd_b; alu_op = cmd_op. Go to EXEC.
  - EXEC: one settle cycle with cmd_ready=0. At the end of the cycle, capture rsp_y=alu_y, rsp_flags={alu_c,alu_v,alu_n,alu_z}, acc_reg=alu_y. Set rsp_valid=1 and go to RESP.
  - RESP: cmd_ready=0. Hold rsp_y, rsp_flags, rsp_valid, alu_a, alu_b and alu_op stable while rsp_ready=0. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
- Latency: accept edge to rsp_valid=1 is 2 clock edges. Minimum throughput is one command per 3 cycles (IDLE, EXEC, RESP).
- No combinational path from cmd_valid to alu_* or rsp_*. cmd_ready is decoded from the state register only.
- acc_reg updates only at the EXEC capture and is unaffected by backpressure. Chaining after reset uses acc_reg=0.
- Flags are captured exactly as the ALU presents them. The ALU already masks C, V and N for logical ops; the sequencer applies no masking.
- Width rules: no extension or truncation; all buses are WIDTH or OPW exactly.
- Boundary conditions:
  - cmd_valid held high continuously: the next command is accepted only on return to IDLE. Inputs changing during EXEC/RESP are ignored.
  - rsp_ready high before rsp_valid: no effect.
  - rsp_ready held low indefinitely: the block stalls in RESP with no loss of data.
  - Reset asserted mid-EXEC or mid-RESP: the in-flight result is discarded, all outputs go to reset values asynchronously, and no response is emitted after reset release.
  - Opcodes with no defined ALU function are still issued and captured; the result is whatever the ALU produces.

Test Plan:
- Reset then ADD: op 3'b010, A=0x0003, B=0x0004, rsp_ready=1 -> rsp_valid high 2 edges after accept; rsp_y=0x0007, flags=4'b0000; cmd_ready low for exactly 2 cycles.
- Signed overflow: ADD 0x7FFF+0x0001 -> rsp_y=0x8000, flags {C,V,N,Z}=4'b0110. Then AND (op 3'b000) 0xF0F0&0x0F0F -> rsp_y=0x0000, flags=4'b0001.
- Chaining: ADD 0x0010+0x0020, then cmd_acc=1 with B=0x0005 ADD -> second response 0x0035. Also, cmd_acc=1 immediately after reset with B=0x0009 -> 0x0009.
- Backpressure: hold rsp_ready=0 for 10 cycles after a response -> rsp_y, rsp_flags and alu_* remain stable, cmd_ready stays 0, and a held cmd_valid is not accepted. Raise rsp_ready -> one handshake, then the next command is accepted in the following cycle.
- Async reset mid-RESP: assert rst between clock edges while rsp_valid=1 -> rsp_valid, rsp_y and acc_reg are 0 before the next edge, cmd_ready=1. After release with no command offered, no spurious rsp_valid.
- Back-to-back stream of 8 random commands with random rsp_ready -> every response matches a reference ALU model, in order, with no drops or duplicates.
